// File: rtl/direction_ram.sv
// Direction-code RAM for an (N+1)x(M+1) alignment score matrix, written by (i,j)
// and read back by a traceback walker that streams the path from (N,M) to (0,0).
module direction_ram_tb #(
  parameter int N      = 128,
  parameter int M      = 128,
  parameter int DIR_W  = 3,
  parameter int I_W    = $clog2(N+1),
  parameter int J_W    = $clog2(M+1),
  parameter int ADDR_W = $clog2((N+1)*(M+1))
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [I_W-1:0]   wr_i,
  input  logic [J_W-1:0]   wr_j,
  input  logic [DIR_W-1:0] wr_dir,
  input  logic             tb_start,
  output logic             tb_busy,
  output logic             tb_done,
  output logic             tb_err,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_dir,
  output logic [I_W-1:0]   out_i,
  output logic [J_W-1:0]   out_j
);

  localparam int DEPTH = (N+1)*(M+1);
  localparam logic [I_W-1:0] I_MAX = I_W'(N);
  localparam logic [J_W-1:0] J_MAX = J_W'(M);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_EV   = 3'd2,
    S_EMIT = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  state_t state_q, state_d;
  logic [I_W-1:0]   cur_i_q, cur_i_d, out_i_q, out_i_d;
  logic [J_W-1:0]   cur_j_q, cur_j_d, out_j_q, out_j_d;
  logic [2:0]       out_dir_q, out_dir_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [DIR_W-1:0] mem [DEPTH];
  logic [DIR_W-1:0] rd_data_q;
  logic [ADDR_W-1:0] wr_addr_s, rd_addr_s;
  logic wr_ok_s, diag_s, up_s, left_s, bad_s;

  assign wr_addr_s = ADDR_W'(wr_i) * ADDR_W'(M+1) + ADDR_W'(wr_j);
  assign rd_addr_s = ADDR_W'(cur_i_q) * ADDR_W'(M+1) + ADDR_W'(cur_j_q);
  assign wr_ok_s   = wr_en && !busy_q && (wr_i <= I_MAX) && (wr_j <= J_MAX);

  // Priority decode of the stored code: diag > up > left, upper bits ignored.
  assign diag_s = rd_data_q[2];
  assign up_s   = rd_data_q[1] & ~rd_data_q[2];
  assign left_s = rd_data_q[0] & ~rd_data_q[1] & ~rd_data_q[2];
  assign bad_s  = !(diag_s || up_s || left_s)
                || (diag_s && (cur_i_q == '0 || cur_j_q == '0))
                || (up_s && cur_i_q == '0)
                || (left_s && cur_j_q == '0);

  // RAM array: contents survive rst, read is registered and only issued in RD.
  always_ff @(posedge clk) begin
    if (wr_ok_s) mem[wr_addr_s] <= wr_dir;
    if (state_q == S_RD) rd_data_q <= mem[rd_addr_s];
  end

  // Walker state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cur_i_q     <= I_MAX;
      cur_j_q     <= J_MAX;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_dir_q   <= 3'b000;
      out_i_q     <= '0;
      out_j_q     <= '0;
    end else begin
      state_q     <= state_d;
      cur_i_q     <= cur_i_d;
      cur_j_q     <= cur_j_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_dir_q   <= out_dir_d;
      out_i_q     <= out_i_d;
      out_j_q     <= out_j_d;
    end
  end

  // Next-state logic for the traceback walker.
  always_comb begin
    state_d     = state_q;
    cur_i_d     = cur_i_q;
    cur_j_d     = cur_j_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    out_dir_d   = out_dir_q;
    out_i_d     = out_i_q;
    out_j_d     = out_j_q;
    case (state_q)
      S_IDLE: begin
        if (tb_start) begin
          state_d = S_RD;
          cur_i_d = I_MAX;
          cur_j_d = J_MAX;
          err_d   = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD: begin
        if (cur_i_q == '0 && cur_j_q == '0) begin
          state_d = S_FIN;
        end else begin
          state_d = S_EV;
        end
      end
      S_EV: begin
        if (bad_s) begin
          state_d = S_FIN;
          err_d   = 1'b1;
        end else begin
          state_d     = S_EMIT;
          out_valid_d = 1'b1;
          out_dir_d   = {diag_s, up_s, left_s};
          out_i_d     = cur_i_q;
          out_j_d     = cur_j_q;
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          state_d     = S_RD;
          out_valid_d = 1'b0;
          if (out_dir_q[2] || out_dir_q[1]) begin
            cur_i_d = cur_i_q - I_W'(1);
          end else begin
            cur_i_d = cur_i_q;
          end
          if (out_dir_q[2] || out_dir_q[0]) begin
            cur_j_d = cur_j_q - J_W'(1);
          end else begin
            cur_j_d = cur_j_q;
          end
        end else begin
          state_d = S_EMIT;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_FIN);
  end

  assign tb_busy   = busy_q;
  assign tb_done   = done_q;
  assign tb_err    = err_q;
  assign out_valid = out_valid_q;
  assign out_dir   = out_dir_q;
  assign out_i     = out_i_q;
  assign out_j     = out_j_q;

endmodule

// File: tb/tb_direction_ram_tb.sv
// Scoreboard bench: instance A is 4x4, instance B is 2x3; expected beats are queued
// before each traceback and popped as the walker hands them over.
module tb_direction_ram_tb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic out_ready = 1'b1;
  logic [2:0] wr_i = 3'd0, wr_j = 3'd0, wr_dir = 3'd0;
  logic wr_en_a = 1'b0, wr_en_b = 1'b0, start_a = 1'b0, start_b = 1'b0;

  logic a_busy, a_done, a_err, a_valid;
  logic [2:0] a_dir, a_i, a_j;
  logic b_busy, b_done, b_err, b_valid;
  logic [2:0] b_dir;
  logic [1:0] b_i, b_j;

  logic sel_b = 1'b0;
  logic v_busy, v_done, v_err, v_valid;
  logic [2:0] v_dir;
  logic [3:0] v_i, v_j;

  int n_cmp = 0;
  int n_bad = 0;
  logic [10:0] exp_q[$];

  always #5 clk = ~clk;

  direction_ram_tb #(.N(4), .M(4)) dut_a (
    .clk(clk), .rst(rst), .wr_en(wr_en_a), .wr_i(wr_i), .wr_j(wr_j), .wr_dir(wr_dir),
    .tb_start(start_a), .tb_busy(a_busy), .tb_done(a_done), .tb_err(a_err),
    .out_valid(a_valid), .out_ready(out_ready), .out_dir(a_dir), .out_i(a_i), .out_j(a_j)
  );

  direction_ram_tb #(.N(2), .M(3)) dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_en_b), .wr_i(wr_i[1:0]), .wr_j(wr_j[1:0]), .wr_dir(wr_dir),
    .tb_start(start_b), .tb_busy(b_busy), .tb_done(b_done), .tb_err(b_err),
    .out_valid(b_valid), .out_ready(out_ready), .out_dir(b_dir), .out_i(b_i), .out_j(b_j)
  );

  assign v_busy  = sel_b ? b_busy  : a_busy;
  assign v_done  = sel_b ? b_done  : a_done;
  assign v_err   = sel_b ? b_err   : a_err;
  assign v_valid = sel_b ? b_valid : a_valid;
  assign v_dir   = sel_b ? b_dir   : a_dir;
  assign v_i     = sel_b ? {2'b00, b_i} : {1'b0, a_i};
  assign v_j     = sel_b ? {2'b00, b_j} : {1'b0, a_j};

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] beat(input logic [2:0] d, input int i, input int j);
    return {d, 4'(i), 4'(j)};
  endfunction

  task automatic write_cell(input bit b, input int i, input int j, input logic [2:0] d);
    wr_i = 3'(i);
    wr_j = 3'(j);
    wr_dir = d;
    wr_en_a = !b;
    wr_en_b = b;
    @(negedge clk);
    wr_en_a = 1'b0;
    wr_en_b = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk_eq({tag, "_busy"}, v_busy, 0);
    chk_eq({tag, "_done"}, v_done, 0);
    chk_eq({tag, "_err"}, v_err, 0);
    chk_eq({tag, "_valid"}, v_valid, 0);
    chk_eq({tag, "_dir"}, v_dir, 0);
    chk_eq({tag, "_i"}, v_i, 0);
    chk_eq({tag, "_j"}, v_j, 0);
  endtask

  // Run one traceback on the selected instance; optionally stall the first beat,
  // check cycle timing, or attempt a write to A's (3,3) while the walker is busy.
  task automatic run_trace(input bit b, input bit exp_err, input int stall,
                           input bit chk_time, input bit busy_wr);
    int cyc = 0;
    int first = -1;
    int last = -1;
    bit fin = 1'b0;
    logic [10:0] got, held;
    sel_b = b;
    if (b) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    cyc = 1;
    chk_eq("busy_after_start", v_busy, 1);
    chk_eq("err_cleared", v_err, 0);
    if (busy_wr) begin
      wr_i = 3'd3; wr_j = 3'd3; wr_dir = 3'b001; wr_en_a = 1'b1;
    end
    while (!fin && cyc < 300) begin
      if (cyc == 2) wr_en_a = 1'b0;
      if (v_valid) begin
        got = {v_dir, v_i, v_j};
        if (first < 0) begin
          first = cyc;
          if (chk_time) chk_eq("first_valid_latency", first, 3);
          if (stall > 0) begin
            out_ready = 1'b0;
            for (int k = 0; k < stall; k++) begin
              @(negedge clk);
              cyc++;
              held = {v_dir, v_i, v_j};
              chk_eq("stall_valid", v_valid, 1);
              chk_eq("stall_payload", held, got);
            end
            out_ready = 1'b1;
          end
        end
        if (exp_q.size() == 0) begin
          chk_eq("extra_beat", got, 0);
        end else begin
          chk_eq("beat", got, exp_q.pop_front());
        end
        if (chk_time && last >= 0) chk_eq("beat_gap", cyc - last, 3);
        last = cyc;
      end
      if (v_done) begin
        fin = 1'b1;
        chk_eq("err_at_done", v_err, exp_err);
        chk_eq("busy_in_fin", v_busy, 1);
        if (chk_time) chk_eq("done_latency", cyc, 14);
      end
      @(negedge clk);
      cyc++;
    end
    wr_en_a = 1'b0;
    chk_eq("trace_finished", fin, 1);
    chk_eq("beats_missing", exp_q.size(), 0);
    chk_eq("busy_after_fin", v_busy, 0);
    chk_eq("done_one_cycle", v_done, 0);
    chk_eq("err_sticky", v_err, exp_err);
    exp_q.delete();
  endtask

  task automatic push_diag_a();
    for (int k = 4; k >= 1; k--) exp_q.push_back(beat(3'b100, k, k));
  endtask

  initial begin
    int cnt;
    repeat (3) @(negedge clk);
    sel_b = 1'b0; #1; check_zero("reset_a");
    sel_b = 1'b1; #1; check_zero("reset_b");
    rst = 1'b0;
    @(negedge clk);

    // Diagonal path on 4x4 with cycle timing
    for (int k = 1; k <= 4; k++) write_cell(1'b0, k, k, 3'b100);
    push_diag_a();
    run_trace(1'b0, 1'b0, 0, 1'b1, 1'b0);

    // Mixed path on 2x3 with an up/left tie at the start
    write_cell(1'b1, 2, 3, 3'b011);
    write_cell(1'b1, 1, 3, 3'b001);
    write_cell(1'b1, 1, 2, 3'b100);
    write_cell(1'b1, 0, 1, 3'b001);
    exp_q.push_back(beat(3'b010, 2, 3));
    exp_q.push_back(beat(3'b001, 1, 3));
    exp_q.push_back(beat(3'b100, 1, 2));
    exp_q.push_back(beat(3'b001, 0, 1));
    run_trace(1'b1, 1'b0, 0, 1'b0, 1'b0);

    // All three bits set: diag wins
    write_cell(1'b1, 2, 3, 3'b111);
    exp_q.push_back(beat(3'b100, 2, 3));
    exp_q.push_back(beat(3'b100, 1, 2));
    exp_q.push_back(beat(3'b001, 0, 1));
    run_trace(1'b1, 1'b0, 0, 1'b0, 1'b0);

    // Up at row 0 is an error; then a clean run clears tb_err
    write_cell(1'b1, 2, 3, 3'b011);
    write_cell(1'b1, 1, 3, 3'b010);
    write_cell(1'b1, 0, 3, 3'b010);
    exp_q.push_back(beat(3'b010, 2, 3));
    exp_q.push_back(beat(3'b010, 1, 3));
    run_trace(1'b1, 1'b1, 0, 1'b0, 1'b0);
    write_cell(1'b1, 1, 3, 3'b001);
    exp_q.push_back(beat(3'b010, 2, 3));
    exp_q.push_back(beat(3'b001, 1, 3));
    exp_q.push_back(beat(3'b100, 1, 2));
    exp_q.push_back(beat(3'b001, 0, 1));
    run_trace(1'b1, 1'b0, 0, 1'b0, 1'b0);

    // Backpressure: first beat held for 5 cycles
    push_diag_a();
    run_trace(1'b0, 1'b0, 5, 1'b0, 1'b0);

    // Empty code at (2,2): error, no beat for that cell
    write_cell(1'b0, 2, 2, 3'b000);
    exp_q.push_back(beat(3'b100, 4, 4));
    exp_q.push_back(beat(3'b100, 3, 3));
    run_trace(1'b0, 1'b1, 0, 1'b0, 1'b0);
    write_cell(1'b0, 2, 2, 3'b100);

    // Reset while a beat is pending, then a full rerun from preserved RAM
    sel_b = 1'b0;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    cnt = 0;
    while (!v_valid && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk_eq("reached_emit", v_valid, 1);
    out_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    check_zero("mid_rst");
    push_diag_a();
    run_trace(1'b0, 1'b0, 0, 1'b0, 1'b0);

    // Dropped writes: one while busy, two out of range while idle
    push_diag_a();
    run_trace(1'b0, 1'b0, 0, 1'b0, 1'b1);
    write_cell(1'b0, 5, 0, 3'b001);
    write_cell(1'b0, 1, 7, 3'b001);
    push_diag_a();
    run_trace(1'b0, 1'b0, 0, 1'b0, 1'b0);

    // Valid idle writes are read back
    write_cell(1'b0, 1, 1, 3'b011);
    write_cell(1'b0, 0, 1, 3'b001);
    exp_q.push_back(beat(3'b100, 4, 4));
    exp_q.push_back(beat(3'b100, 3, 3));
    exp_q.push_back(beat(3'b100, 2, 2));
    exp_q.push_back(beat(3'b010, 1, 1));
    exp_q.push_back(beat(3'b001, 0, 1));
    run_trace(1'b0, 1'b0, 0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
